// File: rtl/vector_tail_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : vector_tail_encoder
//  Description : Registered encoder that turns an element mask into a
//                thermometer tail mask above its most significant set bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module vector_tail_encoder #(
    parameter int VECTOR_MASK_LENGTH = 8
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic [VECTOR_MASK_LENGTH-1:0]                 vector_mask,
    input  logic                                          vector_mask_valid,
    output logic [VECTOR_MASK_LENGTH-1:0]                 encoded_vector_mask,
    output logic [$clog2(VECTOR_MASK_LENGTH+1)-1:0]       tail_start,
    output logic                                          mask_empty,
    output logic                                          no_tail,
    output logic                                          encoded_valid
);

    localparam int c_width    = VECTOR_MASK_LENGTH;
    localparam int c_ts_width = $clog2(VECTOR_MASK_LENGTH + 1);

    logic [c_width-1:0]    w_seen;
    logic [c_width-1:0]    w_encoded;
    logic [c_ts_width-1:0] w_tail_start;
    logic                  w_mask_empty;
    logic                  w_no_tail;

    logic [c_width-1:0]    r_encoded;
    logic [c_ts_width-1:0] r_tail_start;
    logic                  r_mask_empty;
    logic                  r_no_tail;
    logic                  r_valid;

    // w_seen[i] is set when any bit at or above i is set, so its complement
    // is exactly the tail (all positions strictly above the head).
    always_comb begin
        logic v_acc;
        v_acc  = 1'b0;
        w_seen = '0;
        for (int i = c_width - 1; i >= 0; i--) begin
            v_acc     = v_acc | vector_mask[i];
            w_seen[i] = v_acc;
        end
    end

    assign w_encoded = ~w_seen;

    // The number of positions at or below the head equals head + 1,
    // and is zero for an empty mask.
    always_comb begin
        w_tail_start = '0;
        for (int i = 0; i < c_width; i++) begin
            w_tail_start = w_tail_start + c_ts_width'(w_seen[i]);
        end
    end

    assign w_mask_empty = ~w_seen[0];
    assign w_no_tail    = vector_mask[c_width-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_encoded    <= '0;
            r_tail_start <= '0;
            r_mask_empty <= 1'b0;
            r_no_tail    <= 1'b0;
            r_valid      <= 1'b0;
        end else begin
            r_valid <= vector_mask_valid;
            if (vector_mask_valid) begin
                r_encoded    <= w_encoded;
                r_tail_start <= w_tail_start;
                r_mask_empty <= w_mask_empty;
                r_no_tail    <= w_no_tail;
            end
        end
    end

    assign encoded_vector_mask = r_encoded;
    assign tail_start          = r_tail_start;
    assign mask_empty          = r_mask_empty;
    assign no_tail             = r_no_tail;
    assign encoded_valid       = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_vector_tail_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vector_tail_encoder
//  Description : Self-checking bench for vector_tail_encoder (W = 8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_tail_encoder;

    localparam int W  = 8;
    localparam int TW = $clog2(W + 1);
    localparam int RW = W + TW + 3;

    logic          clock;
    logic          reset;
    logic [W-1:0]  vector_mask;
    logic          vector_mask_valid;
    logic [W-1:0]  encoded_vector_mask;
    logic [TW-1:0] tail_start;
    logic          mask_empty;
    logic          no_tail;
    logic          encoded_valid;

    int total;
    int bad;

    vector_tail_encoder #(.VECTOR_MASK_LENGTH(W)) dut (
        .clock               (clock),
        .reset               (reset),
        .vector_mask         (vector_mask),
        .vector_mask_valid   (vector_mask_valid),
        .encoded_vector_mask (encoded_vector_mask),
        .tail_start          (tail_start),
        .mask_empty          (mask_empty),
        .no_tail             (no_tail),
        .encoded_valid       (encoded_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: locate the head, then derive every field from its position.
    function automatic logic [RW-2:0] model(input logic [W-1:0] m);
        int            h;
        logic [W-1:0]  enc;
        logic [TW-1:0] ts;
        h = -1;
        for (int i = 0; i < W; i++) if (m[i]) h = i;
        for (int i = 0; i < W; i++) enc[i] = (i > h);
        ts = (h < 0) ? TW'(0) : TW'(h + 1);
        return {enc, ts, (m == '0), (h == W - 1)};
    endfunction

    function automatic logic [RW-1:0] observed();
        return {encoded_vector_mask, tail_start, mask_empty, no_tail, encoded_valid};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset             = 1'b1;
        vector_mask       = 8'hFF;
        vector_mask_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            total++;
            if (observed() !== '0) begin
                bad++;
                $display("FAIL reset_cycle%0d got=%h want=%h", c, observed(), {RW{1'b0}});
            end
        end
        reset             = 1'b0;
        vector_mask_valid = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        logic [W-1:0]  masks [6];
        logic [RW-1:0] want  [6];
        masks = '{8'b0010_0100, 8'h00, 8'h80, 8'h81, 8'h01, 8'b0100_0000};
        want  = '{{8'b1100_0000, 4'd6, 1'b0, 1'b0, 1'b1},
                  {8'hFF,        4'd0, 1'b1, 1'b0, 1'b1},
                  {8'h00,        4'd8, 1'b0, 1'b1, 1'b1},
                  {8'h00,        4'd8, 1'b0, 1'b1, 1'b1},
                  {8'hFE,        4'd1, 1'b0, 1'b0, 1'b1},
                  {8'b1000_0000, 4'd7, 1'b0, 1'b0, 1'b1}};
        for (int k = 0; k < 6; k++) begin
            vector_mask       = masks[k];
            vector_mask_valid = 1'b1;
            tick();
            total++;
            if (observed() !== want[k]) begin
                bad++;
                $display("FAIL directed mask=%h got=%h want=%h", masks[k], observed(), want[k]);
            end
        end
        vector_mask_valid = 1'b0;
    endtask

    task automatic test_hold();
        logic [RW-2:0] held;
        vector_mask       = 8'b0001_0110;
        vector_mask_valid = 1'b1;
        held              = model(vector_mask);
        tick();
        vector_mask_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            vector_mask = W'($urandom);
            tick();
            total++;
            if (observed() !== {held, 1'b0}) begin
                bad++;
                $display("FAIL hold_cycle%0d got=%h want=%h", c, observed(), {held, 1'b0});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [RW-1:0] want;
        for (int n = 0; n < 100; n++) begin
            // Bias toward low-valued masks so small heads and zero appear.
            case ($urandom_range(0, 3))
                0:       vector_mask = W'($urandom_range(0, 3));
                1:       vector_mask = W'($urandom) >> $urandom_range(0, W - 1);
                default: vector_mask = W'($urandom);
            endcase
            vector_mask_valid = 1'b1;
            want = {model(vector_mask), 1'b1};
            tick();
            total++;
            if (observed() !== want) begin
                bad++;
                $display("FAIL b2b_%0d mask=%h got=%h want=%h", n, vector_mask, observed(), want);
            end
        end
        vector_mask_valid = 1'b0;
    endtask

    task automatic test_reset_midstream();
        logic [RW-1:0] want;
        for (int n = 0; n < 4; n++) begin
            vector_mask       = W'($urandom) | 8'h10;
            vector_mask_valid = 1'b1;
            tick();
        end
        reset       = 1'b1;
        vector_mask = 8'h3C;
        tick();
        total++;
        if (observed() !== '0) begin
            bad++;
            $display("FAIL midstream_reset got=%h want=%h", observed(), {RW{1'b0}});
        end
        reset       = 1'b0;
        vector_mask = 8'b0000_1001;
        want        = {model(vector_mask), 1'b1};
        tick();
        total++;
        if (observed() !== want) begin
            bad++;
            $display("FAIL after_release got=%h want=%h", observed(), want);
        end
        vector_mask_valid = 1'b0;
        tick();
    endtask

    initial begin
        total             = 0;
        bad               = 0;
        reset             = 1'b0;
        vector_mask       = '0;
        vector_mask_valid = 1'b0;
        test_reset();
        test_directed();
        test_hold();
        test_back_to_back();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vector_tail_encoder.md
VECTOR_TAIL_ENCODER -- requirements
Module: vector_tail_encoder

Interface
REQ-001 The block SHALL have the parameter VECTOR_MASK_LENGTH, default 8, giving the mask width W; legal range is W >= 2.
REQ-002 The port clock SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-003 The port reset SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-004 The port vector_mask SHALL be an input, W bits wide: the element mask; bit i belongs to element i.
REQ-005 The port vector_mask_valid SHALL be an input, 1 bit wide: qualifies vector_mask for capture.
REQ-006 The port encoded_vector_mask SHALL be an output, W bits wide: the tail mask; bit i = 1 means element i is a tail element.
REQ-007 The port tail_start SHALL be an output, $clog2(W+1) bits wide: the index of the first tail element; W means there is no tail.
REQ-008 The port mask_empty SHALL be an output, 1 bit wide: the captured mask had no bit set.
REQ-009 The port no_tail SHALL be an output, 1 bit wide: the captured mask had bit W-1 set.
REQ-010 The port encoded_valid SHALL be an output, 1 bit wide: the outputs hold a result captured on the previous edge.

Function
REQ-011 The head index h SHALL be the index of the most significant set bit of vector_mask.
REQ-012 For a non-zero mask, encoded bit i SHALL be 1 exactly when i > h, and tail_start SHALL equal h+1.
REQ-013 For a zero mask, encoded_vector_mask SHALL be all ones, tail_start SHALL be 0 and mask_empty SHALL be 1.
REQ-014 no_tail SHALL be 1 exactly when h = W-1; in that case encoded_vector_mask SHALL be all zeros and tail_start SHALL be W.
REQ-015 The encoded mask SHALL always be a thermometer code: a contiguous run of ones from bit W-1 down to bit tail_start, with zeros below.
REQ-016 Bits below h SHALL NOT affect any output; only the position of the most significant set bit matters.
REQ-017 Latency SHALL be exactly one clock: on an edge with vector_mask_valid = 1 and reset = 0, all result outputs SHALL load the encoding of vector_mask, and encoded_valid SHALL become 1.
REQ-018 On an edge with vector_mask_valid = 0 and reset = 0, encoded_valid SHALL become 0 and all result outputs SHALL hold their previous values.
REQ-019 Back-to-back valid inputs SHALL produce one result per cycle, with no stall and no backpressure.
REQ-020 The outputs SHALL be driven only from registers; there SHALL be no combinational path from an input to an output.
REQ-021 The design SHALL be fully generic in W, using no width-specific lookup tables.

Reset
REQ-022 When reset = 1 at a rising edge, encoded_vector_mask SHALL become 0, tail_start 0, mask_empty 0, no_tail 0 and encoded_valid 0.
REQ-023 Reset SHALL take priority over vector_mask_valid on the same edge; a transfer presented during reset SHALL be discarded.
REQ-024 Before the first reset edge, output values SHALL be undefined; the bench SHALL apply reset first.

Verification (W = 8)
REQ-025 Reset scenario: reset asserted for 2 cycles with vector_mask = 8'hFF and valid = 1 -> all outputs 0, encoded_valid 0.
REQ-026 Mid-range mask: mask 8'b0010_0100 with valid -> next cycle encoded 8'b1100_0000, tail_start 6, mask_empty 0, no_tail 0, encoded_valid 1.
REQ-027 Zero mask: mask 8'h00 with valid -> encoded 8'hFF, tail_start 0, mask_empty 1.
REQ-028 Top bit set: mask 8'h80, then 8'h81, with valid -> encoded 8'h00, tail_start 8, no_tail 1 for both; mask 8'h01 -> encoded 8'hFE, tail_start 1.
REQ-029 Hold behaviour: valid dropped for 3 cycles while vector_mask changes -> encoded_valid 0 and data outputs unchanged; then 100 random masks back-to-back -> each result matches a reference model exactly one cycle later.
REQ-030 Reset mid-stream: reset asserted during a valid stream -> outputs 0 on the next edge, and the first valid after release is encoded correctly.
